// File: rtl/rrf_wb_arbiter.sv
// rtl/rrf_wb_arbiter.sv - round-robin arbiter sharing two RRF write ports among five writeback sources
// Each source owns a one-entry holding buffer; up to two buffers drain per cycle into registered write ports.
module rrf_wb_arbiter #(
    parameter int NUM_SRC  = 5,
    parameter int RRF_SEL  = 6,
    parameter int DATA_LEN = 32
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic [NUM_SRC-1:0]           wb_valid_i,
    input  logic [NUM_SRC*RRF_SEL-1:0]   wb_rrftag_i,
    input  logic [NUM_SRC*DATA_LEN-1:0]  wb_data_i,
    output logic [NUM_SRC-1:0]           wb_ready_o,
    output logic                         rrf_we0_o,
    output logic [RRF_SEL-1:0]           rrf_tag0_o,
    output logic [DATA_LEN-1:0]          rrf_data0_o,
    output logic                         rrf_we1_o,
    output logic [RRF_SEL-1:0]           rrf_tag1_o,
    output logic [DATA_LEN-1:0]          rrf_data1_o,
    output logic [2:0]                   pending_cnt_o
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]  buf_valid_q, buf_valid_d;
    logic [RRF_SEL-1:0]  buf_tag_q  [NUM_SRC];
    logic [RRF_SEL-1:0]  buf_tag_d  [NUM_SRC];
    logic [DATA_LEN-1:0] buf_data_q [NUM_SRC];
    logic [DATA_LEN-1:0] buf_data_d [NUM_SRC];
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic                rrf_we0_q, rrf_we0_d;
    logic [RRF_SEL-1:0]  rrf_tag0_q, rrf_tag0_d;
    logic [DATA_LEN-1:0] rrf_data0_q, rrf_data0_d;
    logic                rrf_we1_q, rrf_we1_d;
    logic [RRF_SEL-1:0]  rrf_tag1_q, rrf_tag1_d;
    logic [DATA_LEN-1:0] rrf_data1_q, rrf_data1_d;
    logic [2:0]          pending_cnt_q, pending_cnt_d;

    logic                grant0_vld, grant1_vld;
    logic [PTR_W-1:0]    grant0_idx, grant1_idx;
    logic [PTR_W-1:0]    cand;
    logic [NUM_SRC-1:0]  granted;

    function automatic logic [PTR_W-1:0] wrap_idx(input int base, input int off);
        int sum;
        sum = base + off;
        if (sum >= NUM_SRC) sum = sum - NUM_SRC;
        return PTR_W'(sum);
    endfunction

    // Scan buffers from rr_ptr; the first hit goes to port 0, the second to port 1.
    always_comb begin
        grant0_vld = 1'b0;
        grant1_vld = 1'b0;
        grant0_idx = '0;
        grant1_idx = '0;
        cand       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = wrap_idx(int'(rr_ptr_q), k);
            if (buf_valid_q[cand]) begin
                if (!grant0_vld) begin
                    grant0_vld = 1'b1;
                    grant0_idx = cand;
                end else if (!grant1_vld) begin
                    grant1_vld = 1'b1;
                    grant1_idx = cand;
                end
            end
        end
    end

    always_comb begin
        granted = '0;
        if (grant0_vld) granted[grant0_idx] = 1'b1;
        if (grant1_vld) granted[grant1_idx] = 1'b1;
    end

    // Ready depends on registered state only, so there is no valid-to-ready path.
    assign wb_ready_o = ~buf_valid_q | granted;

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (wb_valid_i[i] && wb_ready_o[i]) begin
                buf_valid_d[i] = 1'b1;
                buf_tag_d[i]   = wb_rrftag_i[i*RRF_SEL +: RRF_SEL];
                buf_data_d[i]  = wb_data_i[i*DATA_LEN +: DATA_LEN];
            end else if (granted[i]) begin
                buf_valid_d[i] = 1'b0;
            end
        end
        if (flush_i) buf_valid_d = '0;
    end

    // On flush the tag/data outputs hold, so flushed contents never reach the ports.
    always_comb begin
        rrf_we0_d   = grant0_vld & ~flush_i;
        rrf_tag0_d  = rrf_tag0_q;
        rrf_data0_d = rrf_data0_q;
        rrf_we1_d   = grant1_vld & ~flush_i;
        rrf_tag1_d  = rrf_tag1_q;
        rrf_data1_d = rrf_data1_q;
        if (grant0_vld && !flush_i) begin
            rrf_tag0_d  = buf_tag_q[grant0_idx];
            rrf_data0_d = buf_data_q[grant0_idx];
        end
        if (grant1_vld && !flush_i) begin
            rrf_tag1_d  = buf_tag_q[grant1_idx];
            rrf_data1_d = buf_data_q[grant1_idx];
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (flush_i)         rr_ptr_d = '0;
        else if (grant1_vld) rr_ptr_d = wrap_idx(int'(grant1_idx), 1);
        else if (grant0_vld) rr_ptr_d = wrap_idx(int'(grant0_idx), 1);
    end

    always_comb begin
        pending_cnt_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pending_cnt_d = pending_cnt_d + {2'b00, buf_valid_d[i]};
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            buf_valid_q   <= '0;
            rr_ptr_q      <= '0;
            rrf_we0_q     <= 1'b0;
            rrf_tag0_q    <= '0;
            rrf_data0_q   <= '0;
            rrf_we1_q     <= 1'b0;
            rrf_tag1_q    <= '0;
            rrf_data1_q   <= '0;
            pending_cnt_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                buf_tag_q[i]  <= '0;
                buf_data_q[i] <= '0;
            end
        end else begin
            buf_valid_q   <= buf_valid_d;
            rr_ptr_q      <= rr_ptr_d;
            rrf_we0_q     <= rrf_we0_d;
            rrf_tag0_q    <= rrf_tag0_d;
            rrf_data0_q   <= rrf_data0_d;
            rrf_we1_q     <= rrf_we1_d;
            rrf_tag1_q    <= rrf_tag1_d;
            rrf_data1_q   <= rrf_data1_d;
            pending_cnt_q <= pending_cnt_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                buf_tag_q[i]  <= buf_tag_d[i];
                buf_data_q[i] <= buf_data_d[i];
            end
        end
    end

    assign rrf_we0_o     = rrf_we0_q;
    assign rrf_tag0_o    = rrf_tag0_q;
    assign rrf_data0_o   = rrf_data0_q;
    assign rrf_we1_o     = rrf_we1_q;
    assign rrf_tag1_o    = rrf_tag1_q;
    assign rrf_data1_o   = rrf_data1_q;
    assign pending_cnt_o = pending_cnt_q;

endmodule

// File: tb/tb_rrf_wb_arbiter.sv
// tb/tb_rrf_wb_arbiter.sv - directed self-checking bench for rrf_wb_arbiter
module tb_rrf_wb_arbiter;

    localparam int NUM_SRC  = 5;
    localparam int RRF_SEL  = 6;
    localparam int DATA_LEN = 32;

    logic                        clk_i;
    logic                        reset_i;
    logic                        flush_i;
    logic [NUM_SRC-1:0]          wb_valid_i;
    logic [NUM_SRC*RRF_SEL-1:0]  wb_rrftag_i;
    logic [NUM_SRC*DATA_LEN-1:0] wb_data_i;
    logic [NUM_SRC-1:0]          wb_ready_o;
    logic                        rrf_we0_o;
    logic [RRF_SEL-1:0]          rrf_tag0_o;
    logic [DATA_LEN-1:0]         rrf_data0_o;
    logic                        rrf_we1_o;
    logic [RRF_SEL-1:0]          rrf_tag1_o;
    logic [DATA_LEN-1:0]         rrf_data1_o;
    logic [2:0]                  pending_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;
    int hits;

    rrf_wb_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .RRF_SEL  (RRF_SEL),
        .DATA_LEN (DATA_LEN)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .flush_i       (flush_i),
        .wb_valid_i    (wb_valid_i),
        .wb_rrftag_i   (wb_rrftag_i),
        .wb_data_i     (wb_data_i),
        .wb_ready_o    (wb_ready_o),
        .rrf_we0_o     (rrf_we0_o),
        .rrf_tag0_o    (rrf_tag0_o),
        .rrf_data0_o   (rrf_data0_o),
        .rrf_we1_o     (rrf_we1_o),
        .rrf_tag1_o    (rrf_tag1_o),
        .rrf_data1_o   (rrf_data1_o),
        .pending_cnt_o (pending_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_all;
        wb_valid_i = '0;
    endtask

    task automatic set_src(input int i, input logic [RRF_SEL-1:0] tag, input logic [DATA_LEN-1:0] data);
        wb_valid_i[i]                   = 1'b1;
        wb_rrftag_i[i*RRF_SEL +: RRF_SEL] = tag;
        wb_data_i[i*DATA_LEN +: DATA_LEN] = data;
    endtask

    task automatic chk_ports(input string tag, input logic we0, input logic [5:0] t0,
                             input logic we1, input logic [5:0] t1);
        chk({tag, "_we0"}, rrf_we0_o, we0);
        if (we0) chk({tag, "_tag0"}, rrf_tag0_o, t0);
        chk({tag, "_we1"}, rrf_we1_o, we1);
        if (we1) chk({tag, "_tag1"}, rrf_tag1_o, t1);
    endtask

    initial begin
        reset_i     = 1'b0;
        flush_i     = 1'b0;
        wb_valid_i  = '0;
        wb_rrftag_i = '0;
        wb_data_i   = '0;
        tick;
        tick;

        // Reset state
        chk("rst_we0", rrf_we0_o, 0);
        chk("rst_we1", rrf_we1_o, 0);
        chk("rst_tag0", rrf_tag0_o, 0);
        chk("rst_data0", rrf_data0_o, 0);
        chk("rst_data1", rrf_data1_o, 0);
        chk("rst_pend", pending_cnt_o, 0);
        chk("rst_ready", wb_ready_o, 5'b11111);
        reset_i = 1'b1;
        tick;

        // Single write from source 0
        set_src(0, 6'd3, 32'hA5A5_0001);
        tick;
        clr_all;
        chk("s1_pend", pending_cnt_o, 1);
        chk("s1_early_we0", rrf_we0_o, 0);
        tick;
        chk_ports("s1", 1'b1, 6'd3, 1'b0, 6'd0);
        chk("s1_data0", rrf_data0_o, 32'hA5A5_0001);
        chk("s1_rr", dut.rr_ptr_q, 1);
        chk("s1_pend0", pending_cnt_o, 0);

        // Flush an idle arbiter to park rr_ptr at 0
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        chk("fl_rr", dut.rr_ptr_q, 0);

        // All five sources at once drain in pairs
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 6'(10 + i), 32'hB000_0000 + 32'(10 + i));
        tick;
        clr_all;
        chk("s2_pend5", pending_cnt_o, 5);
        tick;
        chk_ports("s2a", 1'b1, 6'd10, 1'b1, 6'd11);
        chk("s2a_data1", rrf_data1_o, 32'hB000_000B);
        chk("s2a_pend", pending_cnt_o, 3);
        tick;
        chk_ports("s2b", 1'b1, 6'd12, 1'b1, 6'd13);
        chk("s2b_pend", pending_cnt_o, 1);
        tick;
        chk_ports("s2c", 1'b1, 6'd14, 1'b0, 6'd0);
        chk("s2c_data0", rrf_data0_o, 32'hB000_000E);
        chk("s2c_pend", pending_cnt_o, 0);
        chk("s2c_rr", dut.rr_ptr_q, 0);
        tick;
        chk("s2d_we0", rrf_we0_o, 0);

        // Source 3 streams every cycle while source 4 waits once
        set_src(2, 6'd21, 32'hC000_0015);
        tick;
        clr_all;
        chk("s3_pend1", pending_cnt_o, 1);
        set_src(3, 6'd30, 32'hC000_001E);
        set_src(4, 6'd40, 32'hC000_0028);
        chk("s3_ready_e2", wb_ready_o, 5'b11111);
        tick;
        clr_all;
        chk_ports("s3e2", 1'b1, 6'd21, 1'b0, 6'd0);
        chk("s3_rr3", dut.rr_ptr_q, 3);
        chk("s3_pend2", pending_cnt_o, 2);
        set_src(3, 6'd31, 32'hC000_001F);
        chk("s3_rdy3_e3", wb_ready_o[3], 1);
        tick;
        clr_all;
        chk_ports("s3e3", 1'b1, 6'd30, 1'b1, 6'd40);
        chk("s3e3_data1", rrf_data1_o, 32'hC000_0028);
        chk("s3e3_pend", pending_cnt_o, 1);
        set_src(3, 6'd32, 32'hC000_0020);
        chk("s3_rdy3_e4", wb_ready_o[3], 1);
        tick;
        clr_all;
        chk_ports("s3e4", 1'b1, 6'd31, 1'b0, 6'd0);
        chk("s3e4_rr", dut.rr_ptr_q, 4);
        tick;
        chk_ports("s3e5", 1'b1, 6'd32, 1'b0, 6'd0);
        chk("s3e5_pend", pending_cnt_o, 0);

        // Source 2 blocked behind sources 0 and 1, then written exactly once
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        set_src(0, 6'd1, 32'hD000_0001);
        set_src(1, 6'd2, 32'hD000_0002);
        set_src(2, 6'd19, 32'hD000_0013);
        tick;
        clr_all;
        chk("s4_pend3", pending_cnt_o, 3);
        chk("s4_ready", wb_ready_o, 5'b11011);
        set_src(2, 6'd20, 32'hD000_0014);
        hits = 0;
        tick;
        if ((rrf_we0_o && rrf_tag0_o == 6'd20) || (rrf_we1_o && rrf_tag1_o == 6'd20)) hits++;
        chk_ports("s4e2", 1'b1, 6'd1, 1'b1, 6'd2);
        chk("s4e2_rr", dut.rr_ptr_q, 2);
        chk("s4e2_rdy2", wb_ready_o[2], 1);
        tick;
        clr_all;
        if ((rrf_we0_o && rrf_tag0_o == 6'd20) || (rrf_we1_o && rrf_tag1_o == 6'd20)) hits++;
        chk_ports("s4e3", 1'b1, 6'd19, 1'b0, 6'd0);
        for (int c = 0; c < 4; c++) begin
            tick;
            if ((rrf_we0_o && rrf_tag0_o == 6'd20) || (rrf_we1_o && rrf_tag1_o == 6'd20)) hits++;
        end
        chk("s4_once", hits, 1);
        chk("s4_idle_we0", rrf_we0_o, 0);

        // Flush with four buffers occupied and new valids arriving
        for (int i = 0; i < 4; i++) set_src(i, 6'(50 + i), 32'hE000_0000 + 32'(50 + i));
        tick;
        clr_all;
        chk("s5_pend4", pending_cnt_o, 4);
        set_src(0, 6'd60, 32'hE000_003C);
        set_src(1, 6'd61, 32'hE000_003D);
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        clr_all;
        chk_ports("s5fl", 1'b0, 6'd0, 1'b0, 6'd0);
        chk("s5_pend0", pending_cnt_o, 0);
        chk("s5_rr0", dut.rr_ptr_q, 0);
        chk("s5_tag0_hold", rrf_tag0_o, 6'd20);
        chk("s5_tag1_hold", rrf_tag1_o, 6'd2);
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("s5_quiet", {rrf_we0_o, rrf_we1_o}, 2'b00);
        end

        // Asynchronous reset mid-cycle with three writes pending
        for (int i = 0; i < 3; i++) set_src(i, 6'(70 + i), 32'hF000_0000 + 32'(70 + i));
        tick;
        clr_all;
        chk("s6_pend3a", pending_cnt_o, 3);
        set_src(0, 6'd33, 32'hF000_0021);
        set_src(1, 6'd34, 32'hF000_0022);
        tick;
        clr_all;
        chk_ports("s6b", 1'b1, 6'd10 + 6'd60, 1'b1, 6'd11 + 6'd60);
        chk("s6_pend3b", pending_cnt_o, 3);
        #2;
        reset_i = 1'b0;
        #1;
        chk("s6_async_we0", rrf_we0_o, 0);
        chk("s6_async_we1", rrf_we1_o, 0);
        chk("s6_async_tag0", rrf_tag0_o, 0);
        chk("s6_async_data0", rrf_data0_o, 0);
        chk("s6_async_pend", pending_cnt_o, 0);
        chk("s6_async_ready", wb_ready_o, 5'b11111);
        tick;
        reset_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("s6_post_we", {rrf_we0_o, rrf_we1_o}, 2'b00);
            chk("s6_post_pend", pending_cnt_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rrf_wb_arbiter.md
Name: rrf_wb_arbiter

Overview:
- Shares the two physical write ports of the rename register file (RRF) among the five functional-unit writeback sources: alu1, alu2, ldst, mul and branch.
- Each source has a one-entry holding buffer with a valid/ready handshake.
- A round-robin scheduler drains up to two buffered results per cycle into registered RRF write-port outputs.
- Sits between the execution units and the rename unit's forwarding/write inputs; replaces direct per-unit RRF writes.

Parameters:
- NUM_SRC, 5, number of writeback requesters (index 0=alu1, 1=alu2, 2=ldst, 3=mul, 4=branch).
- RRF_SEL, 6, RRF tag width.
- DATA_LEN, 32, result data width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- flush_i  input  1  synchronous flush (misprediction); clears all pending writes.
- wb_valid_i  input  NUM_SRC  per-source result valid.
- wb_rrftag_i  input  NUM_SRC*RRF_SEL  per-source destination tag; source i occupies bits [i*RRF_SEL +: RRF_SEL].
- wb_data_i  input  NUM_SRC*DATA_LEN  per-source result data; source i occupies bits [i*DATA_LEN +: DATA_LEN].
- wb_ready_o  output  NUM_SRC  per-source buffer can accept this cycle.
- rrf_we0_o  output  1  write port 0 enable.
- rrf_tag0_o  output  RRF_SEL  write port 0 tag.
- rrf_data0_o  output  DATA_LEN  write port 0 data.
- rrf_we1_o  output  1  write port 1 enable.
- rrf_tag1_o  output  RRF_SEL  write port 1 tag.
- rrf_data1_o  output  DATA_LEN  write port 1 data.
- pending_cnt_o  output  3  number of occupied holding buffers (0..NUM_SRC).

Behaviour:
- State:
  - buf_valid[i], buf_tag[i], buf_data[i] per source.
  - rr_ptr, width clog2(NUM_SRC), range 0..NUM_SRC-1.
  - Output registers for both write ports.
- Reset (reset_i=0, asynchronous):
  - all buf_valid=0, rr_ptr=0.
  - rrf_we0_o=rrf_we1_o=0; tags and data outputs=0.
  - pending_cnt_o=0; wb_ready_o=all ones (combinational from cleared state).
- Grant (combinational, from buffer state only):
  - Scan sources starting at rr_ptr, wrapping modulo NUM_SRC.
  - First buffer with buf_valid=1 → grant0 (port 0); second → grant1 (port 1).
  - Zero, one or two grants per cycle.
- Ready:
  - wb_ready_o[i] = ~buf_valid[i] | granted[i].
  - No combinational path from wb_valid_i to wb_ready_o.
- Accept: wb_valid_i[i] & wb_ready_o[i] loads buf_tag/buf_data[i] and sets buf_valid[i] at the next edge.
  - Granted and refilled in the same cycle → buffer stays valid with the new data.
  - Granted and not refilled → buf_valid clears.
  - wb_valid_i[i] while not ready → ignored; the source must hold its value.
- Output registers, updated every edge:
  - rrf_we0_o <= grant0 exists; rrf_tag0_o/rrf_data0_o <= the granted buffer's contents (hold previous values when no grant).
  - Port 1 likewise from grant1.
  - Port 0 only ever receives the earlier source in round-robin order.
- Latency: a result accepted at edge N is written to the RRF outputs at edge N+1 at the earliest (two cycles from valid to we). This holds when it is among the first two in scan order.
- rr_ptr update: rr_ptr <= (index of last grant issued this cycle + 1) mod NUM_SRC; unchanged if no grant.
  - Fairness: any buffered source is granted within ceil(NUM_SRC/2)=3 cycles.
- pending_cnt_o: registered popcount of buf_valid after the edge's update.
- flush_i=1 at an edge:
  - all buf_valid<=0, rrf_we0_o/rrf_we1_o<=0, rr_ptr<=0.
  - Inputs presented that cycle are discarded, even if ready was high.
  - Flush has priority over accept and grant.
- Reset asserted mid-operation: all pending writes are lost; no partial write is emitted after deassertion.
- Tag collisions between sources are not checked (the rename unit guarantees unique tags).

Test Plan:
- Reset → all outputs 0 and wb_ready_o=5'b11111. Deassert, then source 0 valid with tag 6'd3, data 32'hA5A5_0001 for one cycle → at edge+1 rrf_we0_o=1, tag0=3, data0=A5A5_0001, rrf_we1_o=0; rr_ptr becomes 1.
- All five sources valid in the same cycle with tags 10..14 → writes occur in pairs: (10,11), then (12,13), then (14, none) on consecutive cycles; pending_cnt_o goes 5,3,1,0.
- Source 3 held valid continuously with rr_ptr=3 while source 4 has one buffered entry → source 4 is granted within 1 cycle. Source 3 sustains a new write every cycle, with ready_o[3]=1 throughout.
- Buffer 2 full and not granted (rr_ptr=0, sources 0 and 1 buffered) → wb_ready_o[2]=0. Source 2 holds tag 20 → it is written exactly once, the cycle after sources 0 and 1 drain; no duplicate write.
- flush_i pulsed with 4 buffers occupied and new valids on sources 0 and 1 → next cycle rrf_we0_o=rrf_we1_o=0, pending_cnt_o=0, rr_ptr=0; no flushed tag ever appears on the outputs.
- Asynchronous reset asserted mid-cycle with 3 buffers pending → outputs clear immediately without waiting for a clock edge. After release, no write enables occur until new valids arrive.
